set12_time_setter: RTL and testbench

//   Companion to the 12-hour set-mode display decoder. The decoder renders the

---
 rtl/set12_time_setter_if.sv | 27 ++
 rtl/set12_time_setter.sv | 162 ++++++++++++++++
 tb/tb_set12_time_setter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/set12_time_setter_if.sv
// Signal bundle between the 12-hour set-mode editor and its environment.
// The master drives enable, buttons and live time; the slave returns the edited time.
interface set12_time_setter_if;
  logic       enable;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       cur_pm;
  logic [3:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [1:0] current_state;
  logic       real_quarter;
  logic       is_pm;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic       commit;

  modport master (
    output enable, btn_mode, btn_up, btn_down, cur_pm, cur_hours, cur_minutes,
    input  current_state, real_quarter, is_pm, hours, minutes, commit
  );

  modport slave (
    input  enable, btn_mode, btn_up, btn_down, cur_pm, cur_hours, cur_minutes,
    output current_state, real_quarter, is_pm, hours, minutes, commit
  );
endinterface

// File: rtl/set12_time_setter.sv
// 12-hour set-mode editing FSM: steps AM/PM -> hours -> minutes, edits with wrap,
// generates the blink phase and pulses commit when editing completes.
module set12_time_setter #(
  parameter int unsigned BLINK_DIV = 12_500_000
) (
  input logic               clk,
  input logic               rst_n,
  set12_time_setter_if.slave bus
);

  localparam int unsigned CntW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSetPm   = 2'd1,
    StSetHour = 2'd2,
    StSetMin  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            is_pm_q, is_pm_d;
  logic [3:0]      hours_q, hours_d;
  logic [5:0]      minutes_q, minutes_d;
  logic            commit_q, commit_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rq_q, rq_d;
  logic            enable_q, mode_q, up_q, down_q;

  logic press_mode, press_up, press_down, enable_rise, edit_req, edited;
  logic [3:0] load_hours;
  logic [5:0] load_minutes;

  function automatic logic [3:0] hour_inc(input logic [3:0] h);
    return (h >= 4'd12) ? 4'd1 : h + 4'd1;
  endfunction

  function automatic logic [3:0] hour_dec(input logic [3:0] h);
    return (h <= 4'd1) ? 4'd12 : h - 4'd1;
  endfunction

  function automatic logic [5:0] min_inc(input logic [5:0] m);
    return (m >= 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  function automatic logic [5:0] min_dec(input logic [5:0] m);
    return (m == 6'd0) ? 6'd59 : m - 6'd1;
  endfunction

  assign press_mode  = bus.btn_mode & ~mode_q;
  assign press_up    = bus.btn_up & ~up_q;
  assign press_down  = bus.btn_down & ~down_q;
  assign enable_rise = bus.enable & ~enable_q;
  // Mode outranks edits; simultaneous up+down cancels out.
  assign edit_req    = ~press_mode & (press_up ^ press_down);

  // Out-of-range live values are sanitised so the edited fields are always legal.
  assign load_hours   = ((bus.cur_hours == 4'd0) || (bus.cur_hours > 4'd12)) ? 4'd12
                                                                              : bus.cur_hours;
  assign load_minutes = (bus.cur_minutes > 6'd59) ? 6'd0 : bus.cur_minutes;

  always_comb begin
    state_d   = state_q;
    is_pm_d   = is_pm_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    commit_d  = 1'b0;
    edited    = 1'b0;

    if (!bus.enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable_rise || press_mode) begin
            state_d   = StSetPm;
            is_pm_d   = bus.cur_pm;
            hours_d   = load_hours;
            minutes_d = load_minutes;
          end
        end
        StSetPm: begin
          if (press_mode) begin
            state_d = StSetHour;
          end else if (edit_req) begin
            is_pm_d = ~is_pm_q;
            edited  = 1'b1;
          end
        end
        StSetHour: begin
          if (press_mode) begin
            state_d = StSetMin;
          end else if (edit_req) begin
            hours_d = press_up ? hour_inc(hours_q) : hour_dec(hours_q);
            edited  = 1'b1;
          end
        end
        StSetMin: begin
          if (press_mode) begin
            state_d  = StIdle;
            commit_d = 1'b1;
          end else if (edit_req) begin
            minutes_d = press_up ? min_inc(minutes_q) : min_dec(minutes_q);
            edited    = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Restarting the blink on any change keeps the field just touched visibly lit.
  always_comb begin
    cnt_d = cnt_q;
    rq_d  = rq_q;
    if ((state_d != state_q) || edited) begin
      cnt_d = '0;
      rq_d  = 1'b1;
    end else if (cnt_q == CntMax) begin
      cnt_d = '0;
      rq_d  = ~rq_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      is_pm_q   <= 1'b0;
      hours_q   <= 4'd12;
      minutes_q <= 6'd0;
      commit_q  <= 1'b0;
      cnt_q     <= '0;
      rq_q      <= 1'b1;
      enable_q  <= 1'b0;
      mode_q    <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_pm_q   <= is_pm_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      commit_q  <= commit_d;
      cnt_q     <= cnt_d;
      rq_q      <= rq_d;
      enable_q  <= bus.enable;
      mode_q    <= bus.btn_mode;
      up_q      <= bus.btn_up;
      down_q    <= bus.btn_down;
    end
  end

  assign bus.current_state = state_q;
  assign bus.is_pm         = is_pm_q;
  assign bus.hours         = hours_q;
  assign bus.minutes       = minutes_q;
  assign bus.commit        = commit_q;
  assign bus.real_quarter  = rq_q;

endmodule

// File: tb/tb_set12_time_setter.sv
// Bench for set12_time_setter: directed scenarios with literal expectations plus
// randomized stimulus checked every cycle against an arithmetic reference model.
module tb_set12_time_setter;

  localparam int Div = 4;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 0;

  set12_time_setter_if bus ();

  set12_time_setter #(.BLINK_DIV(Div)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int state;
    int pm;
    int hours;
    int minutes;
    int commit;
    int since;   // edges since the blink phase last restarted
    bit en_q;
    bit mode_q;
    bit up_q;
    bit dn_q;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.state = 0; r.pm = 0; r.hours = 12; r.minutes = 0; r.commit = 0; r.since = 0;
    r.en_q = 0; r.mode_q = 0; r.up_q = 0; r.dn_q = 0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t c, input bit en, input bit bm,
                                        input bit bu, input bit bd, input bit cpm,
                                        input int ch, input int cm);
    model_t n;
    bit pmode, pu, pd, edited;
    n      = c;
    pmode  = bm && !c.mode_q;
    pu     = bu && !c.up_q;
    pd     = bd && !c.dn_q;
    edited = 0;
    n.commit = 0;
    if (!en) begin
      n.state = 0;
    end else if (c.state == 0) begin
      if (!c.en_q || pmode) begin
        n.state   = 1;
        n.pm      = cpm;
        n.hours   = (ch < 1 || ch > 12) ? 12 : ch;
        n.minutes = (cm > 59) ? 0 : cm;
      end
    end else if (pmode) begin
      n.commit = (c.state == 3) ? 1 : 0;
      n.state  = (c.state + 1) % 4;
    end else if (pu != pd) begin
      edited = 1;
      if (c.state == 1) n.pm = 1 - c.pm;
      else if (c.state == 2) n.hours = pu ? (c.hours % 12) + 1 : ((c.hours + 10) % 12) + 1;
      else n.minutes = pu ? (c.minutes + 1) % 60 : (c.minutes + 59) % 60;
    end
    n.since  = (n.state != c.state || edited) ? 0 : c.since + 1;
    n.en_q   = en;
    n.mode_q = bm;
    n.up_q   = bu;
    n.dn_q   = bd;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else m <= model_step(m, bus.enable, bus.btn_mode, bus.btn_up, bus.btn_down, bus.cur_pm,
                         int'(bus.cur_hours), int'(bus.cur_minutes));
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model state", int'(bus.current_state), m.state);
      chk("model is_pm", int'(bus.is_pm), m.pm);
      chk("model hours", int'(bus.hours), m.hours);
      chk("model minutes", int'(bus.minutes), m.minutes);
      chk("model commit", int'(bus.commit), m.commit);
      chk("model real_quarter", int'(bus.real_quarter), ((m.since / Div) % 2 == 0) ? 1 : 0);
    end
  end

  // Press lands on the next edge; buttons are released at the following negedge.
  task automatic tap(input bit bm, input bit bu, input bit bd);
    bus.btn_mode = bm;
    bus.btn_up   = bu;
    bus.btn_down = bd;
    @(negedge clk);
    bus.btn_mode = 0;
    bus.btn_up   = 0;
    bus.btn_down = 0;
  endtask

  task automatic gap();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " state"}, int'(bus.current_state), 0);
    chk({tag, " is_pm"}, int'(bus.is_pm), 0);
    chk({tag, " hours"}, int'(bus.hours), 12);
    chk({tag, " minutes"}, int'(bus.minutes), 0);
    chk({tag, " real_quarter"}, int'(bus.real_quarter), 1);
    chk({tag, " commit"}, int'(bus.commit), 0);
  endtask

  initial begin
    int up_exp[3];
    int dn_exp[4];
    up_exp = '{1, 2, 3};
    dn_exp = '{2, 1, 12, 11};

    rst_n           = 0;
    bus.enable      = 0;
    bus.btn_mode    = 0;
    bus.btn_up      = 0;
    bus.btn_down    = 0;
    bus.cur_pm      = 0;
    bus.cur_hours   = 0;
    bus.cur_minutes = 0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    chk_en = 1;
    rst_n  = 1;
    gap();

    // Entry with illegal live hours/minutes
    bus.cur_pm      = 1;
    bus.cur_hours   = 4'd0;
    bus.cur_minutes = 6'd63;
    bus.enable      = 1;
    gap();
    chk("entry state", int'(bus.current_state), 1);
    chk("entry is_pm", int'(bus.is_pm), 1);
    chk("entry hours", int'(bus.hours), 12);
    chk("entry minutes", int'(bus.minutes), 0);

    tap(1, 0, 0);
    chk("to hour", int'(bus.current_state), 2);
    gap();
    for (int i = 0; i < 3; i++) begin
      tap(0, 1, 0);
      chk("hour up", int'(bus.hours), up_exp[i]);
      gap();
    end
    for (int i = 0; i < 4; i++) begin
      tap(0, 0, 1);
      chk("hour down", int'(bus.hours), dn_exp[i]);
      gap();
    end

    tap(1, 0, 0);
    chk("to min", int'(bus.current_state), 3);
    gap();
    tap(0, 0, 1);
    chk("min 0 down", int'(bus.minutes), 59);
    gap();
    tap(0, 1, 0);
    chk("min 59 up", int'(bus.minutes), 0);
    gap();
    tap(0, 0, 1);
    chk("min down again", int'(bus.minutes), 59);
    gap();
    tap(0, 1, 1);
    chk("min up+down", int'(bus.minutes), 59);
    gap();
    tap(1, 1, 0);
    chk("mode beats up state", int'(bus.current_state), 0);
    chk("mode beats up min", int'(bus.minutes), 59);
    chk("commit first", int'(bus.commit), 1);
    gap();
    chk("commit one cycle", int'(bus.commit), 0);

    tap(1, 0, 0);
    chk("reenter", int'(bus.current_state), 1);
    gap();
    for (int i = 0; i < 3; i++) begin
      tap(1, 0, 0);
      chk("mode walk", int'(bus.current_state), (i + 2) % 4);
      chk("mode walk commit", int'(bus.commit), (i == 2) ? 1 : 0);
      gap();
      chk("commit low after", int'(bus.commit), 0);
    end

    // Blink phase in SET_PM with Div=4
    tap(1, 0, 0);
    chk("blink entry", int'(bus.real_quarter), 1);
    for (int k = 1; k <= 9; k++) begin
      gap();
      chk("blink free", int'(bus.real_quarter), ((k / 4) % 2 == 0) ? 1 : 0);
    end
    bus.btn_up = 1;
    gap();
    chk("blink restart", int'(bus.real_quarter), 1);
    chk("pm toggle", int'(bus.is_pm), 0);
    gap();
    gap();
    chk("held acts once", int'(bus.is_pm), 0);
    bus.btn_up = 0;
    for (int k = 3; k <= 8; k++) begin
      gap();
      chk("blink after edit", int'(bus.real_quarter), ((k / 4) % 2 == 0) ? 1 : 0);
    end

    // Async reset in the middle of SET_MIN
    bus.enable = 0;
    gap();
    chk("abort idle", int'(bus.current_state), 0);
    bus.cur_hours   = 4'd5;
    bus.cur_minutes = 6'd37;
    bus.enable      = 1;
    gap();
    chk("load hours", int'(bus.hours), 5);
    chk("load minutes", int'(bus.minutes), 37);
    tap(1, 0, 0);
    gap();
    tap(1, 0, 0);
    chk("pre-reset state", int'(bus.current_state), 3);
    chk("pre-reset minutes", int'(bus.minutes), 37);
    #3;
    rst_n = 0;
    #1;
    chk_reset_vals("async reset");
    @(negedge clk);
    rst_n = 1;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #2;
      rst_n           = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      bus.enable      = ($urandom_range(0, 99) < 96);
      bus.btn_mode    = ($urandom_range(0, 3) == 0);
      bus.btn_up      = ($urandom_range(0, 2) == 0);
      bus.btn_down    = ($urandom_range(0, 2) == 0);
      bus.cur_pm      = 1'($urandom_range(0, 1));
      bus.cur_hours   = 4'($urandom_range(0, 15));
      bus.cur_minutes = 6'($urandom_range(0, 63));
    end
    @(negedge clk);
    #2;
    rst_n = 1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
